// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage of a Y86-style pipeline.
// Takes one retired-execute instruction at a time. It performs at most one
// data-memory req/ack transaction per instruction and pulses the result into
// the register file for one cycle. It also keeps the processor status code
// and the sticky halt flag.
module mem_wb_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter logic [3:0]  RNONE   = 4'hF,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [3:0]        ex_icode,
  input  logic [DATA_W-1:0] ex_valE,
  input  logic [DATA_W-1:0] ex_valA,
  input  logic [3:0]        ex_dstE,
  input  logic [3:0]        ex_dstM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_err,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        dstE,
  output logic [DATA_W-1:0] valE,
  output logic [3:0]        dstM,
  output logic [DATA_W-1:0] valM,
  output logic [2:0]        stat,
  output logic              halted
);

  localparam int unsigned    CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } stateT;

  typedef enum logic [2:0] {
    C_NOMEM,
    C_READ,
    C_WRITE,
    C_HALT,
    C_INVALID
  } opClassT;

  // Map an instruction code to the kind of memory work it needs.
  function automatic opClassT classify(input logic [3:0] icode);
    opClassT cls;
    case (icode)
      4'h0:                         cls = C_HALT;
      4'h1, 4'h2, 4'h3, 4'h6, 4'h7: cls = C_NOMEM;
      4'h5, 4'h9, 4'hB:             cls = C_READ;
      4'h4, 4'h8, 4'hA:             cls = C_WRITE;
      default:                      cls = C_INVALID;
    endcase
    return cls;
  endfunction

  stateT              state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [3:0]         latDstE, latDstENext;
  logic [3:0]         latDstM, latDstMNext;
  logic [DATA_W-1:0]  latValE, latValENext;
  logic               latIsRead, latIsReadNext;

  logic               readyNext;
  logic               memReqNext, memWeNext;
  logic [DATA_W-1:0]  memAddrNext, memWdataNext;
  logic [3:0]         dstENext, dstMNext;
  logic [DATA_W-1:0]  valENext, valMNext;
  logic [2:0]         statNext;
  logic               haltedNext;
  logic               accept;

  // Next-state, memory request and write-back decisions for the coming edge.
  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    latDstENext   = latDstE;
    latDstMNext   = latDstM;
    latValENext   = latValE;
    latIsReadNext = latIsRead;
    memReqNext    = mem_req;
    memWeNext     = mem_we;
    memAddrNext   = mem_addr;
    memWdataNext  = mem_wdata;
    dstENext      = RNONE;
    dstMNext      = RNONE;
    valENext      = '0;
    valMNext      = '0;
    statNext      = stat;
    haltedNext    = halted;
    accept        = ex_valid && ex_ready;

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (classify(ex_icode))
            C_NOMEM: begin
              dstENext = ex_dstE;
              valENext = ex_valE;
              dstMNext = ex_dstM;
            end
            C_READ: begin
              stateNext     = S_WAIT;
              memReqNext    = 1'b1;
              memWeNext     = 1'b0;
              memAddrNext   = (ex_icode == 4'h5) ? ex_valE : ex_valA;
              latIsReadNext = 1'b1;
              latDstENext   = ex_dstE;
              latDstMNext   = ex_dstM;
              latValENext   = ex_valE;
              cntNext       = '0;
            end
            C_WRITE: begin
              stateNext     = S_WAIT;
              memReqNext    = 1'b1;
              memWeNext     = 1'b1;
              memAddrNext   = ex_valE;
              memWdataNext  = ex_valA;
              latIsReadNext = 1'b0;
              latDstENext   = ex_dstE;
              latDstMNext   = ex_dstM;
              latValENext   = ex_valE;
              cntNext       = '0;
            end
            C_HALT: begin
              statNext   = STAT_HLT;
              haltedNext = 1'b1;
            end
            default: begin
              statNext   = STAT_INS;
              haltedNext = 1'b1;
            end
          endcase
        end
      end

      S_WAIT: begin
        if (mem_ack) begin
          stateNext  = S_IDLE;
          memReqNext = 1'b0;
          if (mem_err) begin
            statNext   = STAT_ADR;
            haltedNext = 1'b1;
          end else begin
            dstENext = latDstE;
            valENext = latValE;
            dstMNext = latDstM;
            valMNext = latIsRead ? mem_rdata : '0;
          end
        end else if (cnt == CNT_LAST) begin
          // No response in time: treated exactly like a faulted access.
          stateNext  = S_IDLE;
          memReqNext = 1'b0;
          statNext   = STAT_ADR;
          haltedNext = 1'b1;
        end else begin
          cntNext = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        end
      end

      default: begin
        stateNext  = S_IDLE;
        memReqNext = 1'b0;
      end
    endcase

    readyNext = (stateNext == S_IDLE) && !haltedNext;
  end

  // State, memory-port and write-back registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      latDstE   <= RNONE;
      latDstM   <= RNONE;
      latValE   <= '0;
      latIsRead <= 1'b0;
      ex_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      dstE      <= RNONE;
      valE      <= '0;
      dstM      <= RNONE;
      valM      <= '0;
      stat      <= STAT_AOK;
      halted    <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      latDstE   <= latDstENext;
      latDstM   <= latDstMNext;
      latValE   <= latValENext;
      latIsRead <= latIsReadNext;
      ex_ready  <= readyNext;
      mem_req   <= memReqNext;
      mem_we    <= memWeNext;
      mem_addr  <= memAddrNext;
      mem_wdata <= memWdataNext;
      dstE      <= dstENext;
      valE      <= valENext;
      dstM      <= dstMNext;
      valM      <= valMNext;
      stat      <= statNext;
      halted    <= haltedNext;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_wb_stage;

  localparam int unsigned DW = 32;
  localparam logic [3:0]  RN = 4'hF;
  localparam int          TO = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ex_valid = 1'b0;
  logic          ex_ready;
  logic [3:0]    ex_icode = 4'h1;
  logic [DW-1:0] ex_valE = '0;
  logic [DW-1:0] ex_valA = '0;
  logic [3:0]    ex_dstE = RN;
  logic [3:0]    ex_dstM = RN;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ack = 1'b0;
  logic          mem_err = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [3:0]    dstE, dstM;
  logic [DW-1:0] valE, valM;
  logic [2:0]    stat;
  logic          halted;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  mem_wb_stage #(.DATA_W(DW), .RNONE(RN), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_icode(ex_icode),
    .ex_valE(ex_valE), .ex_valA(ex_valA), .ex_dstE(ex_dstE), .ex_dstM(ex_dstM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_err(mem_err), .mem_rdata(mem_rdata),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM),
    .stat(stat), .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  int  respDelay  = 1;   // ack on the Nth cycle mem_req is seen high; 0 = never
  bit  respErr    = 1'b0;
  bit  respFixed  = 1'b0;
  bit  respRandom = 1'b0;
  logic [DW-1:0] respData = '0;
  int  reqCycles = 0;

  always @(negedge clock) begin
    if (reset || !mem_req) begin
      reqCycles = 0;
      mem_ack   = 1'b0;
      mem_err   = 1'b0;
    end else begin
      reqCycles++;
      if (respRandom && reqCycles == 1) begin
        respDelay = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
        respErr   = ($urandom_range(0, 15) == 0);
      end
      if (respDelay != 0 && reqCycles == respDelay) begin
        mem_ack   = 1'b1;
        mem_err   = respErr;
        mem_rdata = respFixed ? respData : DW'($urandom);
      end else begin
        mem_ack   = 1'b0;
        mem_err   = 1'($urandom_range(0, 1));
        mem_rdata = DW'($urandom);
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  bit            mHalted = 1'b0;
  logic [2:0]    mStat = 3'd1;
  bit            mBusy = 1'b0;
  int            mAge = 0;
  bit            tRead = 1'b0;
  logic [DW-1:0] tAddr = '0, tData = '0, tValE = '0;
  logic [3:0]    tDstE = RN, tDstM = RN;
  bit            mRetire = 1'b0;
  logic [3:0]    eDstE = RN, eDstM = RN;
  logic [DW-1:0] eValE = '0, eValM = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mHalted = 1'b0; mStat = 3'd1; mBusy = 1'b0; mAge = 0;
      mRetire = 1'b0; eDstE = RN; eDstM = RN; eValE = '0; eValM = '0;
    end else begin
      mRetire = 1'b0; eDstE = RN; eDstM = RN;
      if (mBusy) begin
        if (mem_ack) begin
          mBusy = 1'b0;
          if (mem_err) begin
            mHalted = 1'b1; mStat = 3'd3;
          end else begin
            mRetire = 1'b1;
            eDstE = tDstE; eValE = tValE;
            eDstM = tDstM; eValM = tRead ? mem_rdata : '0;
          end
        end else begin
          mAge++;
          if (mAge >= TO) begin
            mBusy = 1'b0; mHalted = 1'b1; mStat = 3'd3;
          end
        end
      end else if (!mHalted && ex_valid) begin
        if (ex_icode inside {4'h1, 4'h2, 4'h3, 4'h6, 4'h7}) begin
          mRetire = 1'b1;
          eDstE = ex_dstE; eValE = ex_valE; eDstM = ex_dstM; eValM = '0;
        end else if (ex_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB}) begin
          mBusy = 1'b1; mAge = 0;
          tRead = ex_icode inside {4'h5, 4'h9, 4'hB};
          tAddr = (ex_icode inside {4'h9, 4'hB}) ? ex_valA : ex_valE;
          tData = ex_valA;
          tDstE = ex_dstE; tDstM = ex_dstM; tValE = ex_valE;
        end else if (ex_icode == 4'h0) begin
          mHalted = 1'b1; mStat = 3'd2;
        end else begin
          mHalted = 1'b1; mStat = 3'd4;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (started) begin
      chk("ex_ready", 32'(ex_ready), 32'(!mBusy && !mHalted));
      chk("mem_req", 32'(mem_req), 32'(mBusy));
      if (mBusy) begin
        chk("mem_we", 32'(mem_we), 32'(!tRead));
        chk("mem_addr", mem_addr, tAddr);
        if (!tRead) chk("mem_wdata", mem_wdata, tData);
      end
      chk("dstE", 32'(dstE), 32'(eDstE));
      chk("dstM", 32'(dstM), 32'(eDstM));
      if (mRetire) begin
        chk("valE", valE, eValE);
        chk("valM", valM, eValM);
      end
      chk("stat", 32'(stat), 32'(mStat));
      chk("halted", 32'(halted), 32'(mHalted));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] ic, input logic [DW-1:0] ve, input logic [DW-1:0] va,
                       input logic [3:0] de, input logic [3:0] dm);
    ex_valid = 1'b1; ex_icode = ic; ex_valE = ve; ex_valA = va; ex_dstE = de; ex_dstM = dm;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
  endtask

  // Called at negedge+1; leaves the stage freshly reset at the next negedge+1.
  task automatic resetPulse();
    idle();
    reset = 1'b1;
    @(negedge clock); #1;
    reset = 1'b0;
  endtask

  // mem_req was high at the current negedge; count cycles until it drops (bounded).
  task automatic waitReqDrop(output int n);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!mem_req) break;
      n++;
    end
    chk("req_drop_bound", 32'(mem_req), 32'd0);
  endtask

  int n;
  logic [3:0] ic;

  initial begin
    @(negedge clock);
    started = 1'b1;
    chk("rst_dstE", 32'(dstE), 32'hF);
    chk("rst_dstM", 32'(dstM), 32'hF);
    chk("rst_valE", valE, 32'h0);
    chk("rst_stat", 32'(stat), 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ready", 32'(ex_ready), 32'd1);
    #1 reset = 1'b0;

    // back-to-back no-memory ops
    drive(4'h3, 32'hABCDEF98, 32'h0, 4'd2, RN);
    @(negedge clock);
    chk("b2b_dstE0", 32'(dstE), 32'd2);
    chk("b2b_valE0", valE, 32'hABCDEF98);
    chk("b2b_dstM0", 32'(dstM), 32'hF);
    chk("b2b_ready0", 32'(ex_ready), 32'd1);
    #1 drive(4'h6, 32'h7654321A, 32'h0, 4'd3, RN);
    @(negedge clock);
    chk("b2b_dstE1", 32'(dstE), 32'd3);
    chk("b2b_valE1", valE, 32'h7654321A);
    chk("b2b_ready1", 32'(ex_ready), 32'd1);
    #1 idle();
    @(negedge clock);
    chk("idle_dstE", 32'(dstE), 32'hF);
    #1;

    // mrmovl, ack on the third request cycle
    respDelay = 3; respErr = 1'b0; respFixed = 1'b1; respData = 32'h12345678;
    drive(4'h5, 32'h40, 32'h0, RN, 4'd1);
    @(negedge clock);
    chk("mr_req", 32'(mem_req), 32'd1);
    chk("mr_we", 32'(mem_we), 32'd0);
    chk("mr_addr", mem_addr, 32'h40);
    chk("mr_ready", 32'(ex_ready), 32'd0);
    #1 idle();
    waitReqDrop(n);
    chk("mr_req_cycles", 32'(n), 32'd3);
    chk("mr_dstM", 32'(dstM), 32'd1);
    chk("mr_valM", valM, 32'h12345678);
    chk("mr_dstE", 32'(dstE), 32'hF);
    #1;

    // popl: address from valA, both ports written together
    respDelay = 1; respData = 32'h55;
    drive(4'hB, 32'h84, 32'h80, 4'd4, 4'd4);
    @(negedge clock);
    chk("pop_addr", mem_addr, 32'h80);
    #1 idle();
    waitReqDrop(n);
    chk("pop_dstE", 32'(dstE), 32'd4);
    chk("pop_valE", valE, 32'h84);
    chk("pop_dstM", 32'(dstM), 32'd4);
    chk("pop_valM", valM, 32'h55);
    #1;

    // pushl faulted by the memory
    respDelay = 2; respErr = 1'b1;
    drive(4'hA, 32'h7C, 32'h99, 4'd4, RN);
    @(negedge clock);
    chk("push_we", 32'(mem_we), 32'd1);
    chk("push_wdata", mem_wdata, 32'h99);
    chk("push_addr", mem_addr, 32'h7C);
    #1 idle();
    waitReqDrop(n);
    chk("push_stat", 32'(stat), 32'd3);
    chk("push_halted", 32'(halted), 32'd1);
    chk("push_dstE", 32'(dstE), 32'hF);
    chk("push_dstM", 32'(dstM), 32'hF);
    #1 drive(4'h3, 32'h1, 32'h0, 4'd2, RN);
    @(negedge clock);
    chk("push_ready", 32'(ex_ready), 32'd0);
    chk("push_noretire", 32'(dstE), 32'hF);
    #1 respErr = 1'b0;
    resetPulse();

    // rmmovl with no ack: timeout after TO request cycles
    respDelay = 0;
    drive(4'h4, 32'h200, 32'h5, RN, RN);
    @(negedge clock);
    #1 idle();
    waitReqDrop(n);
    chk("to_req_cycles", 32'(n), 32'd4);
    chk("to_stat", 32'(stat), 32'd3);
    chk("to_halted", 32'(halted), 32'd1);
    #1 resetPulse();

    // halt, then invalid opcode
    drive(4'h0, 32'h0, 32'h0, RN, RN);
    @(negedge clock);
    chk("hlt_stat", 32'(stat), 32'd2);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_ready", 32'(ex_ready), 32'd0);
    #1 drive(4'h3, 32'h9, 32'h0, 4'd1, RN);
    @(negedge clock);
    chk("hlt_blocked", 32'(dstE), 32'hF);
    #1 resetPulse();
    drive(4'hD, 32'h0, 32'h0, 4'd1, 4'd2);
    @(negedge clock);
    chk("ins_stat", 32'(stat), 32'd4);
    chk("ins_ready", 32'(ex_ready), 32'd0);
    chk("ins_dstE", 32'(dstE), 32'hF);
    #1 resetPulse();

    // reset in the middle of a wait
    respDelay = 0;
    drive(4'h5, 32'h100, 32'h0, RN, 4'd2);
    @(negedge clock);
    chk("rw_addr", mem_addr, 32'h100);
    #1 idle();
    @(negedge clock);
    #1 reset = 1'b1;
    #1;
    chk("rw_req_drop", 32'(mem_req), 32'd0);
    chk("rw_dstM", 32'(dstM), 32'hF);
    chk("rw_stat", 32'(stat), 32'd1);
    @(negedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rw_ready", 32'(ex_ready), 32'd1);
    chk("rw_no_wb", 32'(dstM), 32'hF);
    #1;

    // randomized traffic, checked by the per-cycle compare
    respRandom = 1'b1; respFixed = 1'b0;
    for (int epoch = 0; epoch < 30; epoch++) begin
      resetPulse();
      for (int c = 0; c < 60; c++) begin
        if ($urandom_range(0, 39) == 0) begin
          n  = int'($urandom_range(0, 4));
          ic = (n == 0) ? 4'h0 : 4'(11 + n);
        end else begin
          ic = 4'($urandom_range(1, 11));
        end
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_icode = ic;
        ex_valE  = DW'($urandom);
        ex_valA  = DW'($urandom);
        ex_dstE  = 4'($urandom_range(0, 15));
        ex_dstM  = 4'($urandom_range(0, 15));
        @(negedge clock);
        #1;
      end
    end
    idle();
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
